// File: rtl/onchip_pixel_writer.sv
// onchip_pixel_writer: packs a stream of 8-bit pixels, four per 32-bit word
// (little-endian), and writes each word to an Avalon-style on-chip memory
// starting at a programmable word address. Start/busy/done command control.
module onchip_pixel_writer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_pixels,
  output logic                  busy,
  output logic                  done,
  input  logic                  pix_valid,
  input  logic [7:0]            pix_data,
  output logic                  pix_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [WORD_W-1:0]      pack_q, pack_d;

  logic                   busy_d, done_d, ready_d, wr_d;
  logic [3:0]             be_d;
  logic [ADDR_WIDTH-1:0]  waddr_d;
  logic [WORD_W-1:0]      wdata_d;

  logic                   accept;
  logic                   last;
  logic [WORD_W-1:0]      merged;
  logic [3:0]             lane_be;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, counter, packing and registered-output next values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    pack_d  = pack_q;
    wr_d    = 1'b0;
    be_d    = mem_byteenable;
    waddr_d = mem_address;
    wdata_d = mem_writedata;

    accept = pix_valid && (state_q == FILL);
    last   = (rem_q == CNT_WIDTH'(1));
    merged = pack_q | (WORD_W'(pix_data) << {lane_q, 3'b000});

    // byte enables cover every lane up to and including the current one
    case (lane_q)
      2'd0:    lane_be = 4'h1;
      2'd1:    lane_be = 4'h3;
      2'd2:    lane_be = 4'h7;
      default: lane_be = 4'hF;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_pixels;
          lane_d  = '0;
          pack_d  = '0;
          state_d = (num_pixels == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          rem_d  = rem_q - CNT_WIDTH'(1);
          lane_d = lane_q + LANE_W'(1);
          if ((lane_q == LANE_W'(3)) || last) begin
            pack_d  = '0;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            wr_d    = 1'b1;
            be_d    = lane_be;
            waddr_d = addr_q;
            wdata_d = merged;
          end else begin
            pack_d = merged;
          end
          if (last) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    ready_d = (state_d == FILL);
  end

  // Datapath and output registers; reset discards any partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q         <= '0;
      rem_q          <= '0;
      lane_q         <= '0;
      pack_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pix_ready      <= 1'b0;
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_byteenable <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      lane_q         <= lane_d;
      pack_q         <= pack_d;
      busy           <= busy_d;
      done           <= done_d;
      pix_ready      <= ready_d;
      mem_write      <= wr_d;
      mem_chipselect <= wr_d;
      mem_byteenable <= be_d;
      mem_address    <= waddr_d;
      mem_writedata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_onchip_pixel_writer.sv
// Testbench for onchip_pixel_writer: scoreboard of expected memory writes plus
// per-scenario handshake and timing checks.
`timescale 1ns/1ps
module tb_onchip_pixel_writer;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_pixels;
  logic          busy, done;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_ready;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [31:0]   mem_writedata;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onchip_pixel_writer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_pixels    (num_pixels),
    .busy          (busy),
    .done          (done),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .mem_address   (mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata)
  );

  // Memory-side monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mem_write === 1'b1 || mem_chipselect === 1'b1) begin
      checks++;
      if (mem_write !== mem_chipselect) begin
        errors++;
        $display("FAIL cs_eq_write: write=%b chipselect=%b", mem_write, mem_chipselect);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h be=%h", mem_address, mem_writedata, mem_byteenable);
      end else begin
        e = sb.pop_front();
        if ({mem_address, mem_writedata, mem_byteenable} !== {e.addr, e.data, e.be}) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h be=%h, expected addr=%h data=%h be=%h",
                   mem_address, mem_writedata, mem_byteenable, e.addr, e.data, e.be);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected words for pixels first, first+1, ... packed little-endian
  function automatic void push_expected(input logic [AW-1:0] base, input int n, input logic [7:0] first);
    exp_t e;
    int   l;
    e.addr = base; e.data = '0; e.be = '0;
    for (int i = 0; i < n; i++) begin
      l = i % 4;
      e.data[8*l +: 8] = 8'(first + i);
      e.be[l] = 1'b1;
      if (l == 3 || i == n - 1) begin
        sb.push_back(e);
        e.addr = e.addr + AW'(1);
        e.data = '0;
        e.be   = '0;
      end
    end
  endfunction

  // Issue a command at the current negedge and stream its pixels; returns at
  // the negedge of the cycle after the last accept (or after S+1 for n = 0)
  task automatic run_job(input logic [AW-1:0] base, input int n, input logic [7:0] first,
                         input bit gaps, input bit poke);
    int idx, cyc;
    bit acc;
    push_expected(base, n, first);
    start = 1'b1; base_addr = base; num_pixels = CW'(n);
    @(negedge clk);
    start = 1'b0; base_addr = ~base; num_pixels = '1;
    if (n > 0) begin
      checks++;
      if (pix_ready !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_start: ready=%b busy=%b, expected 1 1", pix_ready, busy);
      end
    end
    idx = 0; cyc = 0;
    while (idx < n) begin
      if (cyc >= 500) begin
        checks++; errors++;
        $display("FAIL accept_timeout: accepted %0d of %0d pixels", idx, n);
        break;
      end
      start     = poke && (cyc == 2);
      if (poke) begin base_addr = '0; num_pixels = CW'(1); end
      pix_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      pix_data  = 8'(first + idx);
      acc       = pix_valid && pix_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; num_pixels = '0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pix_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/ready=%b, expected 000", {busy, done, pix_ready});
    end
    checks++;
    if ({mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: we=%b cs=%b be=%h addr=%h data=%h, expected all 0",
               mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_words();
    run_job(AW'(10'h010), 8, 8'h01, 1'b0, 1'b0);
    checks++;
    if (pix_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_L1: ready=%b busy=%b done=%b, expected 0 1 0", pix_ready, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_done: done=%b busy=%b, expected 1 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_pending: %0d writes missing, expected 0", sb.size());
    end
  endtask

  task automatic test_partial_tail();
    run_job(AW'(10'h020), 6, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL partial_done: done=%b, expected 1", done);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL partial_end: pending=%0d busy=%b, expected 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_gaps();
    run_job(AW'(10'h030), 5, 8'h41, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gaps_end: pending=%0d busy=%b, expected 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_wrap();
    run_job(AW'(10'h3FE), 12, 8'h30, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: pending=%0d busy=%b, expected 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    run_job(AW'(10'h100), 0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b ready=%b, expected 1 1 0", done, busy, pix_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: done=%b busy=%b, expected 0 0", done, busy);
    end
    // next command issued in the very first IDLE cycle, with a stray start mid-run
    run_job(AW'(10'h200), 8, 8'h61, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_end: pending=%0d busy=%b, expected 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; base_addr = AW'(10'h050); num_pixels = CW'(4);
    @(negedge clk);
    start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'h71;
    @(negedge clk);
    pix_data = 8'h72;
    @(negedge clk);
    pix_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pix_ready, mem_write, mem_chipselect} !== 5'b0 ||
        mem_byteenable !== 4'h0 || mem_address !== '0 || mem_writedata !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b ready=%b we=%b cs=%b be=%h addr=%h data=%h, expected all 0",
               busy, done, pix_ready, mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata);
    end
    reset = 1'b0;
    @(negedge clk);
    run_job(AW'(10'h060), 4, 8'hA1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_end: pending=%0d busy=%b, expected 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_tail();
    test_gaps();
    test_wrap();
    test_zero_and_ignored_start();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
